gfx_cmd_queue: RTL and testbench

- Upstream feeder for graphics_card. Buffers CPU-side 16-bit graphics command writes ({instruction, operand}) in a FIFO and replays them onto the graphics card's io_data bus.
- Holds each command stable for a fixed number of cycles, then inserts NOP gap cycles, so the card sees exactly one edge per command. Two identical back-to-back commands are therefore executed twice.
- Decouples CPU write bursts from the card's per-command acceptance rate.

---
 rtl/gfx_cmd_queue.sv | 155 +++++++++++++++
 tb/tb_gfx_cmd_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gfx_cmd_queue.sv
// Purpose: buffers CPU graphics command words and replays each one onto io_data as a hold-then-NOP pulse train.
// Latency: a word written into an empty idle queue at edge k is driven on io_data from edge k+1 for HOLD_CYCLES cycles.
// Backpressure: full is registered; a write while full is dropped and the sticky overflow flag is set.
module gfx_cmd_queue #(
  parameter int          DEPTH       = 16,
  parameter int          HOLD_CYCLES = 4,
  parameter int          GAP_CYCLES  = 1,
  parameter logic [7:0]  NOP_INSTR   = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              io_data,
  output logic                     busy,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  // The counter only ever holds values up to CMAX-1.
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [15:0]   NOP_WORD = {NOP_INSTR, 8'h00};
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [CW-1:0] HOLD_INI = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_INI  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            have_word;
  logic [LW-1:0]   level_nxt;

  assign have_word = (level != '0);
  // full is the registered flag, so a pop on the same edge cannot rescue a write.
  assign push      = wr_en && !full;
  assign busy      = (state != IDLE) || have_word;

  // Pop whenever the FSM is ready to start a new command and a word is queued.
  always_comb begin
    pop = 1'b0;
    if (have_word) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if ((state == GAP) && (cnt == '0)) begin
        pop = 1'b1;
      end
    end
  end

  // Next occupancy: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (!push && pop) begin
      level_nxt = level - LW'(1);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, registered full flag and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt;
      full  <= (level_nxt == DEPTH_L);
      // A dropped write wins over a clear on the same edge.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Output sequencer: drive each word for HOLD_CYCLES, then NOP for GAP_CYCLES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      io_data <= NOP_WORD;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            io_data <= mem[rd_ptr];
            cnt     <= HOLD_INI;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            io_data <= NOP_WORD;
            cnt     <= GAP_INI;
            state   <= GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (pop) begin
              io_data <= mem[rd_ptr];
              cnt     <= HOLD_INI;
              state   <= HOLD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          io_data <= NOP_WORD;
          cnt     <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Purpose: directed self-checking bench for gfx_cmd_queue with default parameters.
// Latency: expectations are hand-derived cycle by cycle (pops every 5 cycles: 4 hold + 1 gap).
// Backpressure: exercises full, dropped writes, overflow set/clear priority and async reset.
module tb_gfx_cmd_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        clr_overflow = 1'b0;
  logic        full;
  logic [4:0]  level;
  logic [15:0] io_data;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Minimal graphics card stand-in: acts once per change of io_data.
  logic        card_clr = 1'b0;
  logic [7:0]  card_fg = 8'h11;
  logic [7:0]  card_bg = 8'h22;
  logic [15:0] card_prev = 16'h0000;

  gfx_cmd_queue dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .level        (level),
    .io_data      (io_data),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // Card model: decode instruction 02 (foreground) and 03 (background) on each new word.
  always @(posedge clk) begin
    if (card_clr) begin
      card_fg = 8'h11;
      card_bg = 8'h22;
    end else if (io_data != card_prev) begin
      if (io_data[15:8] == 8'h02) card_fg = io_data[7:0];
      if (io_data[15:8] == 8'h03) card_bg = io_data[7:0];
    end
    card_prev = io_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fill_word(input int m);
    if (m == 5) return 16'h0055;  // NOP instruction byte must still be replayed verbatim
    return 16'hA000 + 16'(m);
  endfunction

  initial begin
    // Reset held with writes attempted.
    rst = 1'b0;
    wr_en = 1'b1;
    wr_data = 16'h1234;
    repeat (3) tick();
    check("rst_io", io_data, 32'h0000);
    check("rst_level", level, 32'd0);
    check("rst_full", full, 32'd0);
    check("rst_ovf", overflow, 32'd0);
    check("rst_busy", busy, 32'd0);

    // Single command latency, hold and gap.
    rst = 1'b1;
    wr_data = 16'h02FF;
    tick();  // edge k
    wr_en = 1'b0;
    check("one_level_k", level, 32'd1);
    check("one_io_k", io_data, 32'h0000);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("one_hold", io_data, 32'h02FF);
    end
    tick();
    check("one_gap", io_data, 32'h0000);
    check("one_gap_busy", busy, 32'd1);
    tick();
    check("one_idle_busy", busy, 32'd0);

    // Three identical back-to-back commands are replayed three times.
    wr_en = 1'b1;
    wr_data = 16'h03AA;
    tick();
    check("dup_level0", level, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      wr_en = (i <= 2);
      tick();
      if (i <= 15)
        check("dup_io", io_data, (((i - 1) % 5) < 4) ? 32'h03AA : 32'h0000);
      check("dup_level", level, (i < 2) ? 32'd1 : (i < 6) ? 32'd2 : (i < 11) ? 32'd1 : 32'd0);
    end
    check("dup_busy", busy, 32'd0);

    // Fill to full behind the slow output, drop writes, replay all 20 words in order.
    for (int j = 0; j <= 101; j++) begin
      wr_en = (j <= 21);
      wr_data = fill_word(j);
      clr_overflow = (j == 21) || (j == 22);
      tick();
      if (j == 6)  check("fill_lvl5_pushpop", level, 32'd5);
      if (j == 18) check("fill_notfull", full, 32'd0);
      if (j == 19) begin
        check("fill_full", full, 32'd1);
        check("fill_level16", level, 32'd16);
        check("fill_ovf_clear", overflow, 32'd0);
      end
      if (j == 20) begin
        check("drop_ovf", overflow, 32'd1);
        check("drop_level", level, 32'd16);
      end
      if (j == 21) begin
        check("drop_pop_level", level, 32'd15);
        check("drop_pop_full", full, 32'd0);
        check("ovf_set_beats_clr", overflow, 32'd1);
      end
      if (j == 22) check("ovf_cleared", overflow, 32'd0);
      if (j >= 1 && ((j - 1) % 5) == 0 && j <= 96)
        check("fill_order", io_data, 32'(fill_word((j - 1) / 5)));
      if (j >= 5 && ((j - 5) % 5) == 0 && j <= 100)
        check("fill_gap", io_data, 32'h0000);
    end
    check("fill_drained_level", level, 32'd0);
    check("fill_drained_busy", busy, 32'd0);
    clr_overflow = 1'b0;

    // Reset asserted mid-HOLD discards everything immediately.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 16'hC000 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    check("mid_hold_word", io_data, 32'hC001);
    rst = 1'b0;
    #1;
    check("mid_rst_io", io_data, 32'h0000);
    check("mid_rst_level", level, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mid_no_stale", io_data, 32'h0000);
    end
    check("mid_level_after", level, 32'd0);

    // Card integration: foreground then background.
    card_clr = 1'b1;
    tick();
    card_clr = 1'b0;
    wr_en = 1'b1;
    wr_data = 16'h02FF;
    tick();
    wr_data = 16'h0300;
    tick();
    wr_en = 1'b0;
    repeat (12) tick();
    check("card_fg", card_fg, 32'h00FF);
    check("card_bg", card_bg, 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
